// File: rtl/vid_sync_generator.sv
// vid_sync_generator: pixel-phase, sync, display-enable and raster-interrupt timing source
module vid_sync_generator #(
  parameter int H_RES     = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_RES     = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int PIXEL_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] irq_line,
  input  logic        irq_ena,
  output logic [3:0]  pc_ena,
  output logic        hde,
  output logic        vde,
  output logic        hs,
  output logic        vs,
  output logic [47:0] HV_triggers_out,
  output logic        raster_irq,
  output logic [15:0] frame_count
);
  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;
  localparam logic [11:0] H_ACT = 12'(H_RES);
  localparam logic [11:0] V_ACT = 12'(V_RES);
  localparam logic [11:0] HS_BEG = 12'(H_RES + H_FP);
  localparam logic [11:0] HS_END = 12'(H_RES + H_FP + H_SYNC);
  localparam logic [11:0] VS_BEG = 12'(V_RES + V_FP);
  localparam logic [11:0] VS_END = 12'(V_RES + V_FP + V_SYNC);
  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  localparam logic [3:0]  PC_LAST = 4'(PIXEL_DIV - 1);
  logic [11:0] h_cnt, v_cnt;
  logic tick, h_wrap, v_wrap, line_start, hde_n, vde_n, hs_win, vs_win;
  always_comb begin
    tick       = pc_ena == 4'd0;
    h_wrap     = h_cnt == H_LAST;
    v_wrap     = v_cnt == V_LAST;
    line_start = h_cnt == 12'd0;
    hde_n      = h_cnt < H_ACT;
    vde_n      = v_cnt < V_ACT;
    hs_win     = h_cnt >= HS_BEG && h_cnt < HS_END;
    vs_win     = v_cnt >= VS_BEG && v_cnt < VS_END;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pc_ena          <= '0;
      h_cnt           <= '0;
      v_cnt           <= '0;
      frame_count     <= '0;
      hde             <= 1'b0;
      vde             <= 1'b0;
      hs              <= ~HS_POL;
      vs              <= ~VS_POL;
      HV_triggers_out <= '0;
      raster_irq      <= 1'b0;
    end else begin
      pc_ena     <= (PIXEL_DIV == 1 || pc_ena == PC_LAST) ? 4'd0 : pc_ena + 4'd1;
      // cleared on every non-tick clk so the pulse is one clk wide regardless of PIXEL_DIV
      raster_irq <= tick && irq_ena && line_start && v_cnt == irq_line;
      if (tick) begin
        hde             <= hde_n;
        vde             <= vde_n;
        hs              <= hs_win ? HS_POL : ~HS_POL;
        vs              <= vs_win ? VS_POL : ~VS_POL;
        HV_triggers_out <= {20'd0, vde_n, hde_n, line_start && v_cnt == 12'd0, line_start, v_cnt, h_cnt};
        h_cnt           <= h_wrap ? 12'd0 : h_cnt + 12'd1;
        if (h_wrap) v_cnt <= v_wrap ? 12'd0 : v_cnt + 12'd1;
        if (h_wrap && v_wrap) frame_count <= frame_count + 16'd1;
      end
    end
endmodule
